riscv_mem_arbiter: RTL and testbench

RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

---
 rtl/riscv_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_arbiter.sv
// Round-robin arbiter sharing one in-order memory port between the data port and two fetch slots.
// An in-order tag FIFO remembers who issued each request so responses are steered back to the issuer.
module riscv_mem_arbiter #(
    parameter int MAX_OUTST = 4
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic [66:0]                imemreq0_msg,
    input  logic                       imemreq0_val,
    output logic                       imemreq0_rdy,
    output logic [34:0]                imemresp0_msg,
    output logic                       imemresp0_val,

    input  logic [66:0]                imemreq1_msg,
    input  logic                       imemreq1_val,
    output logic                       imemreq1_rdy,
    output logic [34:0]                imemresp1_msg,
    output logic                       imemresp1_val,

    input  logic [66:0]                dmemreq_msg,
    input  logic                       dmemreq_val,
    output logic                       dmemreq_rdy,
    output logic [34:0]                dmemresp_msg,
    output logic                       dmemresp_val,

    output logic [66:0]                memreq_msg,
    output logic                       memreq_val,
    input  logic                       memreq_rdy,
    input  logic [34:0]                memresp_msg,
    input  logic                       memresp_val,

    output logic [$clog2(MAX_OUTST):0] outst_count,
    output logic                       resp_err
);
    localparam int PTR_W = $clog2(MAX_OUTST);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        REQ_DMEM  = 2'd0,
        REQ_IMEM0 = 2'd1,
        REQ_IMEM1 = 2'd2
    } req_id_t;

    req_id_t          last_gnt;
    req_id_t          gnt_idx;
    req_id_t          head_idx;
    logic             gnt_any;
    logic             grant_ok;
    logic [2:0]       req_val;
    logic             full;
    logic             empty;
    logic             fire;
    logic             pop;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    req_id_t          tag_mem [MAX_OUTST];

    function automatic req_id_t rr_next(req_id_t base, int unsigned off);
        int unsigned idx;
        idx = (32'(base) + off) % 3;
        return req_id_t'(idx[1:0]);
    endfunction

    assign req_val = {imemreq1_val, imemreq0_val, dmemreq_val};

    // Search starts one past the last winner, so the last winner is considered last.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = last_gnt;
        for (int unsigned off = 1; off <= 3; off++) begin
            if (!gnt_any && req_val[rr_next(last_gnt, off)]) begin
                gnt_any = 1'b1;
                gnt_idx = rr_next(last_gnt, off);
            end
        end
    end

    always_comb begin
        case (gnt_idx)
            REQ_IMEM0: memreq_msg = imemreq0_msg;
            REQ_IMEM1: memreq_msg = imemreq1_msg;
            default:   memreq_msg = dmemreq_msg;
        endcase
    end

    assign full       = (outst_count == CNT_W'(MAX_OUTST));
    assign empty      = (outst_count == '0);
    assign memreq_val = gnt_any & ~full & ~reset;
    assign fire       = memreq_val & memreq_rdy;
    assign grant_ok   = gnt_any & memreq_rdy & ~full & ~reset;

    assign dmemreq_rdy  = grant_ok & (gnt_idx == REQ_DMEM);
    assign imemreq0_rdy = grant_ok & (gnt_idx == REQ_IMEM0);
    assign imemreq1_rdy = grant_ok & (gnt_idx == REQ_IMEM1);

    assign head_idx = tag_mem[rd_ptr];
    assign pop      = memresp_val & ~empty & ~reset;

    assign dmemresp_val  = pop & (head_idx == REQ_DMEM);
    assign imemresp0_val = pop & (head_idx == REQ_IMEM0);
    assign imemresp1_val = pop & (head_idx == REQ_IMEM1);

    assign dmemresp_msg  = memresp_msg;
    assign imemresp0_msg = memresp_msg;
    assign imemresp1_msg = memresp_msg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt    <= REQ_IMEM1;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outst_count <= '0;
            resp_err    <= 1'b0;
        end else begin
            if (fire) begin
                last_gnt <= gnt_idx;
                wr_ptr   <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (fire && !pop)
                outst_count <= outst_count + 1'b1;
            else if (pop && !fire)
                outst_count <= outst_count - 1'b1;
            if (memresp_val && empty)
                resp_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fire)
            tag_mem[wr_ptr] <= gnt_idx;
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak with occasional resets.
module tb_riscv_mem_arbiter;
    localparam int MAX_OUTST = 4;
    localparam int CW = $clog2(MAX_OUTST) + 1;

    localparam logic [66:0] MSG_D  = 67'h0D;
    localparam logic [66:0] MSG_I0 = 67'h10;
    localparam logic [66:0] MSG_I1 = 67'h11;

    logic          clk = 1'b0;
    logic          reset;
    logic [66:0]   imemreq0_msg, imemreq1_msg, dmemreq_msg, memreq_msg;
    logic          imemreq0_val, imemreq1_val, dmemreq_val, memreq_val;
    logic          imemreq0_rdy, imemreq1_rdy, dmemreq_rdy, memreq_rdy;
    logic [34:0]   imemresp0_msg, imemresp1_msg, dmemresp_msg, memresp_msg;
    logic          imemresp0_val, imemresp1_val, dmemresp_val, memresp_val;
    logic [CW-1:0] outst_count;
    logic          resp_err;

    riscv_mem_arbiter #(.MAX_OUTST(MAX_OUTST)) dut (
        .clk(clk), .reset(reset),
        .imemreq0_msg(imemreq0_msg), .imemreq0_val(imemreq0_val), .imemreq0_rdy(imemreq0_rdy),
        .imemresp0_msg(imemresp0_msg), .imemresp0_val(imemresp0_val),
        .imemreq1_msg(imemreq1_msg), .imemreq1_val(imemreq1_val), .imemreq1_rdy(imemreq1_rdy),
        .imemresp1_msg(imemresp1_msg), .imemresp1_val(imemresp1_val),
        .dmemreq_msg(dmemreq_msg), .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy),
        .dmemresp_msg(dmemresp_msg), .dmemresp_val(dmemresp_val),
        .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
        .memresp_msg(memresp_msg), .memresp_val(memresp_val),
        .outst_count(outst_count), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: owner queue of in-flight requests, last winner, sticky error.
    int tagq[$];
    int last_gnt = 2;
    bit err_m = 1'b0;
    bit p_fire, p_pop, p_err;
    int p_gnt;

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [66:0] req_msg(int i);
        case (i)
            1:       return imemreq0_msg;
            2:       return imemreq1_msg;
            default: return dmemreq_msg;
        endcase
    endfunction

    task automatic model_compare();
        bit [2:0] v;
        bit [2:0] e_rdy, e_rval, a_rdy, a_rval;
        bit full, e_val;
        int cnt;
        v = {imemreq1_val, imemreq0_val, dmemreq_val};
        a_rdy  = {imemreq1_rdy, imemreq0_rdy, dmemreq_rdy};
        a_rval = {imemresp1_val, imemresp0_val, dmemresp_val};
        if (reset) begin
            tagq.delete();
            last_gnt = 2;
            err_m = 1'b0;
            p_fire = 1'b0; p_pop = 1'b0; p_err = 1'b0; p_gnt = -1;
            check("rst_memreq_val", memreq_val, 0);
            check("rst_req_rdy", a_rdy, 0);
            check("rst_resp_val", a_rval, 0);
            check("rst_outst_count", outst_count, 0);
            check("rst_resp_err", resp_err, 0);
            return;
        end
        cnt = tagq.size();
        full = (cnt == MAX_OUTST);
        p_gnt = -1;
        for (int k = 1; k <= 3; k++)
            if (p_gnt < 0 && v[(last_gnt + k) % 3]) p_gnt = (last_gnt + k) % 3;
        e_val = (p_gnt >= 0) && !full;
        e_rdy = 3'b000;
        if (e_val && memreq_rdy) e_rdy[p_gnt] = 1'b1;
        p_fire = e_val && memreq_rdy;
        p_pop  = memresp_val && (cnt > 0);
        p_err  = memresp_val && (cnt == 0);
        e_rval = 3'b000;
        if (p_pop) e_rval[tagq[0]] = 1'b1;
        check("memreq_val", memreq_val, e_val);
        if (e_val) check("memreq_msg", memreq_msg, req_msg(p_gnt));
        check("req_rdy", a_rdy, e_rdy);
        check("resp_val", a_rval, e_rval);
        if (e_rval[0]) check("dmemresp_msg", dmemresp_msg, memresp_msg);
        if (e_rval[1]) check("imemresp0_msg", imemresp0_msg, memresp_msg);
        if (e_rval[2]) check("imemresp1_msg", imemresp1_msg, memresp_msg);
        check("outst_count", outst_count, cnt);
        check("resp_err", resp_err, err_m);
    endtask

    task automatic model_commit();
        if (p_pop) void'(tagq.pop_front());
        if (p_fire) begin
            tagq.push_back(p_gnt);
            last_gnt = p_gnt;
        end
        if (p_err) err_m = 1'b1;
    endtask

    initial begin : compare_proc
        forever begin
            @(negedge clk);
            model_compare();
            @(posedge clk);
            model_commit();
        end
    end

    task automatic set_req(bit d, bit i0, bit i1);
        dmemreq_val = d; imemreq0_val = i0; imemreq1_val = i1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; step(); step();
        reset = 1'b0;
    endtask

    bit [1:0] pipe;

    initial begin : stim
        reset = 1'b1;
        memreq_rdy = 1'b1; memresp_val = 1'b0; memresp_msg = '0;
        dmemreq_msg = MSG_D; imemreq0_msg = MSG_I0; imemreq1_msg = MSG_I1;
        set_req(1, 1, 1);
        step(); step(); #1;
        check("lit_reset_count", outst_count, 0);
        check("lit_reset_memreq_val", memreq_val, 0);
        check("lit_reset_err", resp_err, 0);
        step();
        reset = 1'b0;

        // Round robin with a fixed two-cycle memory
        pipe = 2'b00;
        for (int c = 0; c < 12; c++) begin
            memresp_val = pipe[1];
            memresp_msg = 35'(c + 'h100);
            #1;
            if (c == 0) check("lit_rr_0", memreq_msg, MSG_D);
            if (c == 1) check("lit_rr_1", memreq_msg, MSG_I0);
            if (c == 2) check("lit_rr_2", memreq_msg, MSG_I1);
            if (c == 3) check("lit_rr_3", memreq_msg, MSG_D);
            if (c == 2) check("lit_rr_resp_dmem", dmemresp_val, 1);
            if (c == 8) check("lit_rr_count", outst_count, 2);
            step();
            pipe = {pipe[0], p_fire};
        end
        do_reset();

        // Fill to the limit with fetch slot 0 only
        set_req(0, 1, 0);
        memresp_val = 1'b0;
        repeat (4) step();
        #1;
        check("lit_full_rdy", imemreq0_rdy, 0);
        check("lit_full_count", outst_count, 4);
        memresp_val = 1'b1; memresp_msg = 35'h5;
        #1;
        check("lit_full_resp_route", imemresp0_val, 1);
        check("lit_full_no_grant_on_pop", imemreq0_rdy, 0);
        step();
        memresp_val = 1'b0;
        #1;
        check("lit_after_pop_rdy", imemreq0_rdy, 1);
        do_reset();

        // Interleaved owners, in-order responses
        set_req(1, 0, 0); step();
        set_req(0, 0, 1); step();
        set_req(0, 1, 0); step();
        set_req(0, 0, 0);
        memresp_val = 1'b1;
        memresp_msg = 35'hA; #1;
        check("lit_il_a", {dmemresp_val, 35'(dmemresp_msg)}, {1'b1, 35'hA});
        step();
        memresp_msg = 35'hB; #1;
        check("lit_il_b", {imemresp1_val, 35'(imemresp1_msg)}, {1'b1, 35'hB});
        step();
        memresp_msg = 35'hC; #1;
        check("lit_il_c", {imemresp0_val, 35'(imemresp0_msg)}, {1'b1, 35'hC});
        step();
        memresp_val = 1'b0;

        // Stray response with nothing in flight, then a normal transaction
        memresp_val = 1'b1; #1;
        check("lit_stray_no_val", {dmemresp_val, imemresp0_val, imemresp1_val}, 0);
        step();
        memresp_val = 1'b0; #1;
        check("lit_stray_err", resp_err, 1);
        set_req(1, 0, 0); step();
        set_req(0, 0, 0); memresp_val = 1'b1; memresp_msg = 35'h77; #1;
        check("lit_after_stray_route", dmemresp_val, 1);
        step();
        memresp_val = 1'b0;
        do_reset();

        // Fire and pop together at three in flight
        set_req(0, 0, 1);
        repeat (3) step();
        memresp_val = 1'b1; step();
        memresp_val = 1'b0; set_req(0, 0, 0); #1;
        check("lit_pushpop_count", outst_count, 3);
        do_reset();

        // Reset with two in flight, late response, stalled memory
        set_req(1, 1, 0);
        repeat (2) step();
        set_req(1, 1, 1);
        reset = 1'b1; #1;
        check("lit_async_count", outst_count, 0);
        check("lit_async_memreq_val", memreq_val, 0);
        step(); step();
        reset = 1'b0;
        set_req(0, 0, 0);
        memresp_val = 1'b1; step();
        memresp_val = 1'b0; #1;
        check("lit_late_err", resp_err, 1);
        set_req(1, 1, 1); memreq_rdy = 1'b0;
        repeat (3) step();
        memreq_rdy = 1'b1; #1;
        check("lit_stall_keeps_ptr", memreq_msg, MSG_D);
        step();
        do_reset();

        // Randomized soak
        for (int c = 0; c < 3000; c++) begin
            set_req(1'($urandom), 1'($urandom), 1'($urandom));
            dmemreq_msg  = {3'($urandom), $urandom, $urandom};
            imemreq0_msg = {3'($urandom), $urandom, $urandom};
            imemreq1_msg = {3'($urandom), $urandom, $urandom};
            memreq_rdy   = ($urandom_range(0, 3) != 0);
            memresp_val  = (tagq.size() > 0) && ($urandom_range(0, 2) != 0);
            memresp_msg  = {3'($urandom), $urandom};
            reset        = ($urandom_range(0, 399) == 0);
            step();
        end
        reset = 1'b0;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
